mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 97 +++++++++
 tb/tb_mult_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Sequences two 4-bit operand nibbles into an external combinational multiplier,
// waits for it to settle, then holds the captured product until downstream accepts it.
module mult_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] a,
    output logic [3:0] b,
    input  logic [3:0] pcirc,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic       res_ovf,
    input  logic       res_ready,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_count;
    logic [7:0] product;

    // Full-width product of the held operands, used only to detect overflow of the 4-bit result.
    assign product = {4'b0000, a} * {4'b0000, b};

    // in_ready, busy and res_valid are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= GET_A;
            a            <= 4'd0;
            b            <= 4'd0;
            res_data     <= 4'd0;
            res_ovf      <= 1'b0;
            res_valid    <= 1'b0;
            op_count     <= 8'd0;
            settle_count <= 4'd0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (in_valid && in_ready) begin
                        a     <= in_data;
                        busy  <= 1'b1;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (in_valid && in_ready) begin
                        b            <= in_data;
                        settle_count <= SETTLE_LOAD;
                        in_ready     <= 1'b0;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_count == 4'd0) begin
                        res_data  <= pcirc;
                        res_ovf   <= (product > 8'd15);
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        settle_count <= settle_count - 4'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= GET_A;
                    end
                end
                default: begin
                    state     <= GET_A;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed table, randomized operations against
// an arithmetic reference model, reset corner cases and a longer settle configuration.
module tb_mult_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] pcirc;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ovf;
    logic       res_ready;
    logic       busy;
    logic [7:0] op_count;
    logic [7:0] full_prod;

    logic       in_valid3;
    logic [3:0] in_data3;
    logic       in_ready3;
    logic [3:0] op_a3;
    logic [3:0] op_b3;
    logic [3:0] pcirc3;
    logic       res_valid3;
    logic [3:0] res_data3;
    logic       res_ovf3;
    logic       res_ready3;
    logic       busy3;
    logic [7:0] op_count3;
    logic [7:0] full_prod3;

    int checks = 0;
    int errors = 0;

    mult_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .a(op_a), .b(op_b), .pcirc(pcirc), .res_valid(res_valid), .res_data(res_data),
        .res_ovf(res_ovf), .res_ready(res_ready), .busy(busy), .op_count(op_count)
    );

    mult_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .a(op_a3), .b(op_b3), .pcirc(pcirc3), .res_valid(res_valid3), .res_data(res_data3),
        .res_ovf(res_ovf3), .res_ready(res_ready3), .busy(busy3), .op_count(op_count3)
    );

    // Behavioural stand-in for the external multiplier: truncated product of the operands.
    assign full_prod  = {4'b0000, op_a} * {4'b0000, op_b};
    assign pcirc      = full_prod[3:0];
    assign full_prod3 = {4'b0000, op_a3} * {4'b0000, op_b3};
    assign pcirc3     = full_prod3[3:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [3:0] a_in;
        logic [3:0] b_in;
        int         hold;
        logic [3:0] exp_data;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // Reference model: result is the product modulo 16, overflow when the product exceeds 15.
    function automatic void refModel(input int av, input int bv, output int exp_data, output int exp_ovf);
        int prod;
        prod     = av * bv;
        exp_data = prod % 16;
        exp_ovf  = (prod > 15) ? 1 : 0;
    endfunction

    // One full operation on the default DUT; called and returning #1 after a rising edge.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input int idle,
                                 input int hold, output logic [3:0] got_data,
                                 output logic got_ovf, output int lat);
        in_valid  = 1'b0;
        res_ready = (hold == 0);
        repeat (idle) begin
            in_data = 4'($urandom);
            @(posedge clk); #1;
        end
        checkOutput("in_ready_get_a", int'(in_ready), 1);
        checkOutput("busy_get_a", int'(busy), 0);
        in_valid = 1'b1;
        in_data  = av;
        @(posedge clk); #1;
        checkOutput("busy_get_b", int'(busy), 1);
        checkOutput("in_ready_get_b", int'(in_ready), 1);
        in_data = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        checkOutput("in_ready_settle", int'(in_ready), 0);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("res_valid_rise", int'(res_valid), 1);
        got_data = res_data;
        got_ovf  = res_ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_res_valid", int'(res_valid), 1);
            checkOutput("hold_res_data", int'(res_data), int'(got_data));
            checkOutput("hold_res_ovf", int'(res_ovf), int'(got_ovf));
            checkOutput("hold_a", int'(op_a), int'(av));
            checkOutput("hold_b", int'(op_b), int'(bv));
            checkOutput("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput("res_valid_drop", int'(res_valid), 0);
        checkOutput("in_ready_after", int'(in_ready), 1);
        checkOutput("busy_after", int'(busy), 0);
        checkOutput("a_kept", int'(op_a), int'(av));
        checkOutput("b_kept", int'(op_b), int'(bv));
    endtask

    initial begin
        logic [3:0] got_data;
        logic       got_ovf;
        int         lat;
        int         lat3;
        int         exp_data;
        int         exp_ovf;
        logic [7:0] exp_count;
        logic [3:0] ra;
        logic [3:0] rb;
        bit         seen;

        vecs[0] = '{4'd3,  4'd2,  0,  4'd6,  1'b0};
        vecs[1] = '{4'd4,  4'd5,  0,  4'd4,  1'b1};
        vecs[2] = '{4'd7,  4'd7,  2,  4'd1,  1'b1};
        vecs[3] = '{4'd15, 4'd15, 10, 4'd1,  1'b1};
        vecs[4] = '{4'd8,  4'd0,  0,  4'd0,  1'b0};
        vecs[5] = '{4'd1,  4'd15, 1,  4'd15, 1'b0};
        vecs[6] = '{4'd2,  4'd8,  0,  4'd0,  1'b1};
        vecs[7] = '{4'd0,  4'd0,  3,  4'd0,  1'b0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 4'd0;
        res_ready  = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = 4'd0;
        res_ready3 = 1'b0;
        exp_count  = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_a", int'(op_a), 0);
        checkOutput("reset_b", int'(op_b), 0);
        checkOutput("reset_res_valid", int'(res_valid), 0);
        checkOutput("reset_res_data", int'(res_data), 0);
        checkOutput("reset_op_count", int'(op_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_reset_in_ready", int'(in_ready), 1);
        checkOutput("post_reset_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a_in, vecs[i].b_in, i % 3, vecs[i].hold, got_data, got_ovf, lat);
            exp_count++;
            checkOutput("table_res_data", int'(got_data), int'(vecs[i].exp_data));
            checkOutput("table_res_ovf", int'(got_ovf), int'(vecs[i].exp_ovf));
            checkOutput("table_latency", lat, 1);
            checkOutput("table_op_count", int'(op_count), int'(exp_count));
        end

        for (int i = 8; i < 256; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            applyStimulus(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), got_data, got_ovf, lat);
            refModel(int'(ra), int'(rb), exp_data, exp_ovf);
            exp_count++;
            checkOutput("rand_res_data", int'(got_data), exp_data);
            checkOutput("rand_res_ovf", int'(got_ovf), exp_ovf);
            checkOutput("rand_latency", lat, 1);
            checkOutput("rand_op_count", int'(op_count), int'(exp_count));
        end
        checkOutput("op_count_wrap", int'(op_count), 0);

        // Reset during SETTLE discards the pending 3*2.
        in_valid = 1'b1;
        in_data  = 4'd3;
        @(posedge clk); #1;
        in_data = 4'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("settle_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_settle_res_valid", int'(res_valid), 0);
        checkOutput("rst_settle_a", int'(op_a), 0);
        checkOutput("rst_settle_b", int'(op_b), 0);
        checkOutput("rst_settle_op_count", int'(op_count), 0);
        checkOutput("rst_settle_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        checkOutput("rst_settle_no_result", int'(seen), 0);
        exp_count = 8'd0;
        applyStimulus(4'd2, 4'd3, 0, 0, got_data, got_ovf, lat);
        exp_count++;
        checkOutput("after_rst_res_data", int'(got_data), 6);
        checkOutput("after_rst_res_ovf", int'(got_ovf), 0);
        checkOutput("after_rst_op_count", int'(op_count), int'(exp_count));

        // Reset while a result is held in HOLD.
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("hold_reached", int'(res_valid), 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_hold_res_valid", int'(res_valid), 0);
        checkOutput("rst_hold_op_count", int'(op_count), 0);
        checkOutput("rst_hold_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_hold_stays_idle", int'(res_valid), 0);

        // Longer settle configuration: result arrives two cycles later than the default.
        in_valid3 = 1'b1;
        in_data3  = 4'd5;
        @(posedge clk); #1;
        in_data3 = 4'd3;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat3 = 0;
        while (!res_valid3 && lat3 < 40) begin
            @(posedge clk); #1;
            lat3++;
        end
        checkOutput("settle3_latency", lat3, 3);
        checkOutput("settle3_res_data", int'(res_data3), 15);
        checkOutput("settle3_res_ovf", int'(res_ovf3), 0);
        res_ready3 = 1'b1;
        @(posedge clk); #1;
        res_ready3 = 1'b0;
        checkOutput("settle3_res_valid_drop", int'(res_valid3), 0);
        checkOutput("settle3_op_count", int'(op_count3), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
